toom8_pointwise_scheduler: RTL and testbench
============================================

Name: toom8_pointwise_scheduler

Overview:
- Sequences the 15 pointwise products of one 1024x1024 Toom-8 multiplication (evaluation points 0..14) through a single shared pointwise multiplier.
- Sits between the operand splitting/evaluation stage and the interpolation stage.
- Issues point indices over a valid/ready request channel, tracks outstanding requests, and writes each tagged response into the interpolation result bank.
- Pulses done when all 15 results have been written.

Parameters:
- NUM_POINTS, 15, number of evaluation points per job. Legal range 2..16; index width is fixed at 4 bits.
- MAX_OUTSTANDING, 4, maximum number of issued-but-unreturned requests. Legal range 1..NUM_POINTS.
- RES_W, 266, width of one pointwise product (two signed 133-bit evaluated operands).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job request; accepted only when start_ready=1.
- start_ready  output  1  high in IDLE.
- busy  output  1  high in ISSUE or DRAIN.
- done  output  1  one-cycle pulse at job completion.
- err  output  1  sticky protocol-error flag.
- mul_req_valid  output  1  request valid.
- mul_req_ready  input  1  multiplier accepts the request.
- mul_req_point  output  4  evaluation point index of the request.
- mul_resp_valid  input  1  response valid. There is no backpressure on responses.
- mul_resp_point  input  4  tag of the response.
- mul_resp_data  input  RES_W  product data.
- res_wr_en  output  1  result bank write strobe.
- res_wr_addr  output  4  result bank address (the point index).
- res_wr_data  output  RES_W  result bank write data.

Behaviour:
- Reset values: state=IDLE; start_ready=1; all counters=0; returned mask=0. busy, done, err, mul_req_valid and res_wr_en are 0. mul_req_point, res_wr_addr and res_wr_data are 0.
- IDLE:
  - start=1 moves to ISSUE. issue_idx, outstanding and returned count are cleared, the returned mask is cleared, and err is cleared.
  - A new job never overlaps a running one.
- ISSUE:
  - mul_req_valid = (outstanding < MAX_OUTSTANDING).
  - mul_req_point = issue_idx, driven from a register.
  - Request handshake is mul_req_valid && mul_req_ready. On a handshake, issue_idx increments and outstanding increments.
  - mul_req_valid and mul_req_point stay stable while ready is low.
  - After the handshake for index NUM_POINTS-1, the block moves to DRAIN.
  - First request is valid the cycle after start is accepted. With ready=1 and no outstanding limit hit, the block issues one request per cycle.
- DRAIN: no requests are issued. When returned count reaches NUM_POINTS, the block moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Responses, accepted in ISSUE or DRAIN:
  - The response is registered. One cycle later, res_wr_en=1 with res_wr_addr=mul_resp_point and res_wr_data=mul_resp_data.
  - The returned mask bit is set, the returned count increments and outstanding decrements.
  - The final res_wr_en and the state's arrival in DONE coincide, so done is high in the same cycle as the last write.
- Simultaneous request handshake and response in the same cycle: outstanding is unchanged (+1-1).
- Out-of-order responses are legal; the tag alone selects the address.
- Error cases, all with no write and no counter change:
  - a response whose point index has not been issued, or is >= NUM_POINTS;
  - a duplicate response (its mask bit is already set);
  - any response while in IDLE or DONE.
  - In each case err is set and held until the next accepted start.
- start while busy is ignored.
- rst mid-job returns every register to its reset value on the next edge. Any in-flight multiplier responses then arrive in IDLE and set err; clearing the multiplier is the system's responsibility.

Optional Feature:
- Macro TOOM8_SCHED_PERF_EN.
- When defined, two additional outputs are added:
  - perf_job_cycles[15:0]: cycles from start acceptance to done, saturating.
  - perf_stall_cycles[15:0]: cycles in ISSUE with mul_req_valid=1 and mul_req_ready=0, saturating.
- Both counters load their final values at done, hold until the next done, and reset to 0.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Multiplier model with ready=1, in-order, fixed 3-cycle latency; MAX_OUTSTANDING=4.
  - 15 writes occur, addresses 0..14 each exactly once, data matching the model.
  - Outstanding never exceeds 4; done pulses once; err=0.
- ready toggled low every other cycle.
  - mul_req_point is held stable while stalled; all 15 points are issued in order.
  - With the macro defined, perf_stall_cycles equals the count of stalled cycles.
- Responses returned in reverse order per window of 4 (3,2,1,0,7,...).
  - Every write address equals its tag; done pulses after the 15th write; err=0.
- Inject a duplicate response for point 5, and a response for point 14 before 14 is issued.
  - err=1, no extra write occurs, the job still completes with done.
  - err clears on the next start.
- rst asserted after 6 issues, then start again.
  - All outputs read their reset values the cycle after rst.
  - The second job issues from point 0 and completes normally.
- start held high through an entire job.
  - Exactly one job runs; a second job begins the cycle after done, when IDLE is entered.

Source files
------------

// File: rtl/toom8_pointwise_scheduler_if.sv
// Request/response channel between the Toom-8 pointwise scheduler (master) and the shared
// pointwise multiplier (slave).
interface toom8_pointwise_scheduler_if #(
    parameter int unsigned RES_W = 266
) ();
    logic             mul_req_valid;
    logic             mul_req_ready;
    logic [3:0]       mul_req_point;
    logic             mul_resp_valid;
    logic [3:0]       mul_resp_point;
    logic [RES_W-1:0] mul_resp_data;

    modport master (
        output mul_req_valid,
        output mul_req_point,
        input  mul_req_ready,
        input  mul_resp_valid,
        input  mul_resp_point,
        input  mul_resp_data
    );

    modport slave (
        input  mul_req_valid,
        input  mul_req_point,
        output mul_req_ready,
        output mul_resp_valid,
        output mul_resp_point,
        output mul_resp_data
    );
endinterface

// File: rtl/toom8_pointwise_scheduler.sv
// Toom-8 pointwise-product scheduler: issues points 0..NUM_POINTS-1 to one shared multiplier and
// writes tagged responses into the result bank. Optional perf counters: TOOM8_SCHED_PERF_EN.
module toom8_pointwise_scheduler #(
    parameter int unsigned NUM_POINTS      = 15,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned RES_W           = 266
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        start_ready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    toom8_pointwise_scheduler_if.master mul_if,
    output logic                        res_wr_en_o,
    output logic [3:0]                  res_wr_addr_o,
    output logic [RES_W-1:0]            res_wr_data_o
`ifdef TOOM8_SCHED_PERF_EN
    ,
    output logic [15:0]                 perf_job_cycles_o,
    output logic [15:0]                 perf_stall_cycles_o
`endif
);

    // One extra bit so counts can reach NUM_POINTS = 16.
    localparam int unsigned CntW = 5;
    localparam logic [CntW-1:0] LastIdx = CntW'(NUM_POINTS - 1);
    localparam logic [CntW-1:0] NumPts  = CntW'(NUM_POINTS);
    localparam logic [CntW-1:0] MaxOut  = CntW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   issue_idx_q, issue_idx_d;
    logic [CntW-1:0]   out_q, out_d;
    logic [CntW-1:0]   ret_q, ret_d;
    logic [15:0]       mask_q, mask_d;
    logic              err_q, err_d;
    logic              start_ready_q, busy_q, done_q;
    logic              req_valid_q;
    logic [3:0]        req_point_q;
    logic              res_wr_en_q;
    logic [3:0]        res_wr_addr_q;
    logic [RES_W-1:0]  res_wr_data_q;

    logic              req_hs, resp_active, resp_legal, resp_ok, resp_err;
    logic [CntW-1:0]   resp_pt_ext;

    always_comb begin
        req_hs      = req_valid_q & mul_if.mul_req_ready;
        resp_active = (state_q == StIssue) || (state_q == StDrain);
        resp_pt_ext = {1'b0, mul_if.mul_resp_point};
        // Issue is strictly in order, so "already issued" is simply tag < issue_idx.
        resp_legal  = (resp_pt_ext < NumPts) && (resp_pt_ext < issue_idx_q) &&
                      !mask_q[mul_if.mul_resp_point];
        resp_ok     = mul_if.mul_resp_valid & resp_active & resp_legal;
        resp_err    = mul_if.mul_resp_valid & ~(resp_active & resp_legal);
    end

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        out_d       = out_q + CntW'(req_hs) - CntW'(resp_ok);
        ret_d       = ret_q;
        mask_d      = mask_q;
        err_d       = err_q | resp_err;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StIssue;
                    issue_idx_d = '0;
                    out_d       = '0;
                    ret_d       = '0;
                    mask_d      = '0;
                    err_d       = resp_err;
                end
            end
            StIssue: begin
                if (req_hs && (issue_idx_q == LastIdx)) state_d = StDrain;
            end
            StDrain: begin
                if (resp_ok && ((ret_q + CntW'(1)) == NumPts)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (req_hs) issue_idx_d = issue_idx_q + CntW'(1);
        if (resp_ok) begin
            mask_d[mul_if.mul_resp_point] = 1'b1;
            ret_d = ret_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            issue_idx_q   <= '0;
            out_q         <= '0;
            ret_q         <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            req_point_q   <= '0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            res_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            issue_idx_q   <= issue_idx_d;
            out_q         <= out_d;
            ret_q         <= ret_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            start_ready_q <= (state_d == StIdle);
            busy_q        <= (state_d == StIssue) || (state_d == StDrain);
            done_q        <= (state_d == StDone);
            req_valid_q   <= (state_d == StIssue) && (out_d < MaxOut);
            req_point_q   <= (state_d == StIssue) ? issue_idx_d[3:0] : 4'd0;
            res_wr_en_q   <= resp_ok;
            if (resp_ok) begin
                res_wr_addr_q <= mul_if.mul_resp_point;
                res_wr_data_q <= mul_if.mul_resp_data;
            end
        end
    end

    assign start_ready_o        = start_ready_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign err_o                = err_q;
    assign mul_if.mul_req_valid = req_valid_q;
    assign mul_if.mul_req_point = req_point_q;
    assign res_wr_en_o          = res_wr_en_q;
    assign res_wr_addr_o        = res_wr_addr_q;
    assign res_wr_data_o        = res_wr_data_q;

`ifdef TOOM8_SCHED_PERF_EN
    logic [15:0] job_cnt_q, stall_cnt_q, perf_job_q, perf_stall_q;
    logic [15:0] job_cnt_inc;

    always_comb job_cnt_inc = (job_cnt_q == 16'hffff) ? job_cnt_q : job_cnt_q + 16'd1;

    // Running counters restart at start acceptance; visible values update only at done.
    always_ff @(posedge clk) begin
        if (rst) begin
            job_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            perf_job_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == StIdle) && start_i) begin
                job_cnt_q   <= '0;
                stall_cnt_q <= '0;
            end else if ((state_q == StIssue) || (state_q == StDrain)) begin
                job_cnt_q <= job_cnt_inc;
                if (req_valid_q && !mul_if.mul_req_ready && (stall_cnt_q != 16'hffff)) begin
                    stall_cnt_q <= stall_cnt_q + 16'd1;
                end
            end
            if (state_d == StDone) begin
                perf_job_q   <= job_cnt_inc;
                perf_stall_q <= stall_cnt_q;
            end
        end
    end

    assign perf_job_cycles_o   = perf_job_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_toom8_pointwise_scheduler.sv
// Self-checking bench for toom8_pointwise_scheduler: a behavioural multiplier model drives the
// request/response channel and a scoreboard checks writes, flow control, done and err.
module tb_toom8_pointwise_scheduler;
    localparam int NP    = 15;
    localparam int MO    = 4;
    localparam int RES_W = 266;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             start_ready, busy, done, err, wr_en;
    logic [3:0]       wr_addr;
    logic [RES_W-1:0] wr_data;
`ifdef TOOM8_SCHED_PERF_EN
    logic [15:0]      perf_job, perf_stall;
`endif

    toom8_pointwise_scheduler_if #(.RES_W(RES_W)) mul_if ();

    toom8_pointwise_scheduler #(
        .NUM_POINTS      (NP),
        .MAX_OUTSTANDING (MO),
        .RES_W           (RES_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .start_ready_o (start_ready),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .mul_if        (mul_if),
        .res_wr_en_o   (wr_en),
        .res_wr_addr_o (wr_addr),
        .res_wr_data_o (wr_data)
`ifdef TOOM8_SCHED_PERF_EN
        ,
        .perf_job_cycles_o   (perf_job),
        .perf_stall_cycles_o (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Per-job observations gathered by run_job, judged by the calling test.
    int  n_writes, wr_bad, wr_dup, done_pulses, done_bad, valid_viol, order_viol;
    int  stall_viol, err_viol, busy_viol, max_out, stall_cycles, issued, returned;
    bit  timed_out, aborted, err_at_done;
    bit  written [16];
    logic [RES_W-1:0] data_ref [16];
    int  resp_pt_q[$], resp_due_q[$], win_q[$];

    // ready_mode: 0 always, 1 toggling, 2 random. resp_mode: 0 in-order latency 3,
    // 1 reversed per window of MO.
    task automatic run_job(input int ready_mode, input int resp_mode, input bit inject,
                           input bit hold, input int abort_at);
        int cyc, wait_cyc, pt, prev_point, exp_wr_pt;
        bit exp_wr, prev_stalled, err_exp, inj14, inj5, finished;
        logic [RES_W-1:0] v;
        for (int p = 0; p < 16; p++) begin
            for (int w = 0; w < 9; w++) v = {v[RES_W-33:0], $urandom()};
            data_ref[p] = v;
            written[p]  = 1'b0;
        end
        resp_pt_q.delete(); resp_due_q.delete(); win_q.delete();
        n_writes = 0; wr_bad = 0; wr_dup = 0; done_pulses = 0; done_bad = 0; valid_viol = 0;
        order_viol = 0; stall_viol = 0; err_viol = 0; busy_viol = 0; max_out = 0;
        stall_cycles = 0; issued = 0; returned = 0; timed_out = 0; aborted = 0;
        err_at_done = 1'b0;
        wait_cyc = 0;
        while (start_ready !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (start_ready !== 1'b1) timed_out = 1;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 0; exp_wr = 0; exp_wr_pt = 0; prev_stalled = 0; err_exp = 0;
        inj14 = 0; inj5 = 0; finished = 0; prev_point = 0;
        while (!finished) begin
            if (wr_en === 1'b1) begin
                if (!exp_wr || wr_addr !== 4'(exp_wr_pt) || wr_data !== data_ref[exp_wr_pt])
                    wr_bad++;
                if (written[wr_addr]) wr_dup++;
                written[wr_addr] = 1'b1;
                n_writes++;
            end else if (exp_wr) begin
                wr_bad++;
            end
            if (err !== err_exp) err_viol++;
            if (done === 1'b1) begin
                done_pulses++;
                if (n_writes != NP || wr_en !== 1'b1) done_bad++;
                err_at_done = err;
                finished = 1;
            end else if (n_writes >= NP) begin
                done_bad++;
                finished = 1;
            end
            if (finished) break;
            if (busy !== 1'b1 || start_ready !== 1'b0) busy_viol++;
            if (abort_at > 0 && issued == abort_at) begin
                aborted = 1;
                break;
            end
            if (mul_if.mul_req_valid !== ((issued < NP) && ((issued - returned) < MO)))
                valid_viol++;
            if (mul_if.mul_req_valid === 1'b1 && mul_if.mul_req_point !== 4'(issued))
                order_viol++;
            if (prev_stalled && (mul_if.mul_req_valid !== 1'b1 ||
                                 mul_if.mul_req_point !== 4'(prev_point)))
                stall_viol++;
            case (ready_mode)
                0:       mul_if.mul_req_ready = 1'b1;
                1:       mul_if.mul_req_ready = cyc[0];
                default: mul_if.mul_req_ready = 1'($urandom_range(0, 1));
            endcase
            prev_stalled = (mul_if.mul_req_valid === 1'b1) && !mul_if.mul_req_ready;
            prev_point   = issued;
            if (prev_stalled) stall_cycles++;
            exp_wr = 0;
            mul_if.mul_resp_valid = 1'b0;
            mul_if.mul_resp_point = 4'd0;
            mul_if.mul_resp_data  = '0;
            if (inject && !inj14 && issued >= 2 && issued < 14) begin
                mul_if.mul_resp_valid = 1'b1;
                mul_if.mul_resp_point = 4'd14;
                mul_if.mul_resp_data  = v;
                inj14 = 1; err_exp = 1;
            end else if (inject && !inj5 && written[5]) begin
                mul_if.mul_resp_valid = 1'b1;
                mul_if.mul_resp_point = 4'd5;
                mul_if.mul_resp_data  = v;
                inj5 = 1; err_exp = 1;
            end else if (resp_pt_q.size() > 0 && resp_due_q[0] <= cyc) begin
                pt = resp_pt_q.pop_front();
                void'(resp_due_q.pop_front());
                mul_if.mul_resp_valid = 1'b1;
                mul_if.mul_resp_point = 4'(pt);
                mul_if.mul_resp_data  = data_ref[pt];
                exp_wr = 1; exp_wr_pt = pt;
                returned++;
            end
            if (mul_if.mul_req_valid === 1'b1 && mul_if.mul_req_ready) begin
                if (resp_mode == 0) begin
                    resp_pt_q.push_back(issued);
                    resp_due_q.push_back(cyc + 3);
                end else begin
                    win_q.push_back(issued);
                    if (win_q.size() == MO || issued == NP - 1) begin
                        while (win_q.size() > 0) begin
                            resp_pt_q.push_back(win_q.pop_back());
                            resp_due_q.push_back(cyc + 1);
                        end
                    end
                end
                issued++;
            end
            if (issued - returned > max_out) max_out = issued - returned;
            cyc++;
            if (cyc > 1000) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        mul_if.mul_req_ready  = 1'b0;
        mul_if.mul_resp_valid = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b want 1", start_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        checks++; if (mul_if.mul_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mul_if.mul_req_valid); else passed++;
        checks++; if (mul_if.mul_req_point !== 4'd0) $display("FAIL reset_req_point: got %0d want 0", mul_if.mul_req_point); else passed++;
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== '0) $display("FAIL reset_wr: got en=%b addr=%0d want 0/0", wr_en, wr_addr); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_response();
        mul_if.mul_resp_valid = 1'b1;
        mul_if.mul_resp_point = 4'd3;
        mul_if.mul_resp_data  = '1;
        @(negedge clk);
        mul_if.mul_resp_valid = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL idle_resp_err: got %b want 1", err); else passed++;
        checks++; if (wr_en !== 1'b0) $display("FAIL idle_resp_no_write: got %b want 0", wr_en); else passed++;
    endtask

    task automatic test_in_order();
        run_job(0, 0, 0, 0, 0);
        checks++; if (timed_out) $display("FAIL inorder_timeout: got 1 want 0"); else passed++;
        checks++; if (n_writes != NP || wr_dup != 0) $display("FAIL inorder_writes: got %0d (dup %0d) want %0d", n_writes, wr_dup, NP); else passed++;
        checks++; if (wr_bad != 0) $display("FAIL inorder_addr_data: got %0d bad want 0", wr_bad); else passed++;
        checks++; if (valid_viol != 0 || max_out > MO) $display("FAIL inorder_valid_rule: got %0d viol max_out %0d want 0/<=%0d", valid_viol, max_out, MO); else passed++;
        checks++; if (done_pulses != 1 || done_bad != 0) $display("FAIL inorder_done: got %0d pulses %0d bad want 1/0", done_pulses, done_bad); else passed++;
        checks++; if (err_viol != 0 || err_at_done !== 1'b0) $display("FAIL inorder_err: got %0d viol err=%b want 0/0", err_viol, err_at_done); else passed++;
        checks++; if (busy_viol != 0) $display("FAIL inorder_busy: got %0d want 0", busy_viol); else passed++;
    endtask

    task automatic test_ready_toggle();
        run_job(1, 0, 0, 0, 0);
        checks++; if (stall_viol != 0) $display("FAIL toggle_stall_stable: got %0d want 0", stall_viol); else passed++;
        checks++; if (order_viol != 0 || issued != NP) $display("FAIL toggle_order: got %0d viol %0d issued want 0/%0d", order_viol, issued, NP); else passed++;
        checks++; if (n_writes != NP || wr_bad != 0) $display("FAIL toggle_writes: got %0d (bad %0d) want %0d", n_writes, wr_bad, NP); else passed++;
        checks++; if (valid_viol != 0) $display("FAIL toggle_valid_rule: got %0d want 0", valid_viol); else passed++;
        checks++; if (done_pulses != 1 || err_viol != 0) $display("FAIL toggle_done_err: got %0d pulses %0d err viol want 1/0", done_pulses, err_viol); else passed++;
`ifdef TOOM8_SCHED_PERF_EN
        checks++; if (perf_stall !== 16'(stall_cycles)) $display("FAIL perf_stall: got %0d want %0d", perf_stall, stall_cycles); else passed++;
`endif
    endtask

    task automatic test_reverse_window();
        run_job(0, 1, 0, 0, 0);
        checks++; if (wr_bad != 0 || wr_dup != 0) $display("FAIL reverse_addr_tag: got %0d bad %0d dup want 0/0", wr_bad, wr_dup); else passed++;
        checks++; if (n_writes != NP) $display("FAIL reverse_writes: got %0d want %0d", n_writes, NP); else passed++;
        checks++; if (done_pulses != 1 || done_bad != 0) $display("FAIL reverse_done: got %0d pulses %0d bad want 1/0", done_pulses, done_bad); else passed++;
        checks++; if (err_viol != 0 || valid_viol != 0) $display("FAIL reverse_err_valid: got %0d/%0d want 0/0", err_viol, valid_viol); else passed++;
    endtask

    task automatic test_errors();
        run_job(1, 0, 1, 0, 0);
        checks++; if (err_at_done !== 1'b1) $display("FAIL errors_err_set: got %b want 1", err_at_done); else passed++;
        checks++; if (err_viol != 0) $display("FAIL errors_err_timing: got %0d want 0", err_viol); else passed++;
        checks++; if (n_writes != NP || wr_bad != 0 || wr_dup != 0) $display("FAIL errors_no_extra_write: got %0d (bad %0d dup %0d) want %0d", n_writes, wr_bad, wr_dup, NP); else passed++;
        checks++; if (done_pulses != 1 || done_bad != 0) $display("FAIL errors_done: got %0d pulses want 1", done_pulses); else passed++;
        run_job(0, 0, 0, 0, 0);
        checks++; if (err_viol != 0 || err_at_done !== 1'b0) $display("FAIL errors_clear_on_start: got %0d viol err=%b want 0/0", err_viol, err_at_done); else passed++;
    endtask

    task automatic test_reset_mid_job();
        run_job(0, 0, 0, 0, 6);
        checks++; if (!aborted) $display("FAIL midrst_reached: got 0 want 1"); else passed++;
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) $display("FAIL midrst_status: got sr=%b busy=%b done=%b err=%b want 1/0/0/0", start_ready, busy, done, err); else passed++;
        checks++; if (mul_if.mul_req_valid !== 1'b0 || mul_if.mul_req_point !== 4'd0) $display("FAIL midrst_req: got v=%b pt=%0d want 0/0", mul_if.mul_req_valid, mul_if.mul_req_point); else passed++;
        checks++; if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== '0) $display("FAIL midrst_wr: got en=%b addr=%0d want 0/0 data 0", wr_en, wr_addr); else passed++;
        rst = 1'b0;
        @(negedge clk);
        run_job(0, 0, 0, 0, 0);
        checks++; if (order_viol != 0 || issued != NP) $display("FAIL midrst_reissue: got %0d viol %0d issued want 0/%0d", order_viol, issued, NP); else passed++;
        checks++; if (n_writes != NP || wr_bad != 0 || done_pulses != 1 || err_viol != 0) $display("FAIL midrst_complete: got %0d writes %0d bad %0d done want %0d/0/1", n_writes, wr_bad, done_pulses, NP); else passed++;
    endtask

    task automatic test_start_held();
        run_job(2, 0, 0, 1, 0);
        checks++; if (done_pulses != 1 || n_writes != NP || busy_viol != 0) $display("FAIL held_one_job: got %0d pulses %0d writes %0d busy viol want 1/%0d/0", done_pulses, n_writes, busy_viol, NP); else passed++;
        checks++; if (order_viol != 0 || wr_bad != 0) $display("FAIL held_order: got %0d/%0d want 0/0", order_viol, wr_bad); else passed++;
        @(negedge clk);
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) $display("FAIL held_idle: got sr=%b busy=%b done=%b want 1/0/0", start_ready, busy, done); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || start_ready !== 1'b0) $display("FAIL held_restart: got busy=%b sr=%b want 1/0", busy, start_ready); else passed++;
        checks++; if (mul_if.mul_req_valid !== 1'b1 || mul_if.mul_req_point !== 4'd0) $display("FAIL held_first_req: got v=%b pt=%0d want 1/0", mul_if.mul_req_valid, mul_if.mul_req_point); else passed++;
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            run_job(2, int'($urandom_range(0, 1)), 0, 0, 0);
            checks++; if (n_writes != NP || wr_bad != 0 || wr_dup != 0) $display("FAIL b2b_writes_%0d: got %0d (bad %0d) want %0d", j, n_writes, wr_bad, NP); else passed++;
            checks++; if (done_pulses != 1 || valid_viol != 0 || err_viol != 0 || timed_out) $display("FAIL b2b_flow_%0d: got %0d pulses %0d valid %0d err viol want 1/0/0", j, done_pulses, valid_viol, err_viol); else passed++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mul_if.mul_req_ready  = 1'b0;
        mul_if.mul_resp_valid = 1'b0;
        mul_if.mul_resp_point = 4'd0;
        mul_if.mul_resp_data  = '0;
        test_reset();
        test_idle_response();
        test_in_order();
        test_ready_toggle();
        test_reverse_window();
        test_errors();
        test_reset_mid_job();
        test_start_held();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
